// File: rtl/adder_pipe_pkg.sv
// Shared types and helpers for the pipelined N-bit adder.
// Contents: chunk width helper, saturation constant helpers and the
// per-stage control register struct used by adder_pipe_nbit.
package adder_pipe_pkg;

  // Upper bound on operand width handled by the saturation helpers.
  localparam int MAX_BITS = 64;

  // Control part of one pipeline stage; the data words live beside it
  // because their width depends on the instance parameters.
  typedef struct packed {
    logic vld;    // stage holds a live item
    logic carry;  // carry out of the chunk added in this stage
    logic a_msb;  // operand A sign bit, kept for the overflow check
    logic b_msb;  // operand B sign bit, kept for the overflow check
  } stage_t;

  function automatic int chunk_width(input int num_bits, input int num_stages);
    return num_bits / num_stages;
  endfunction

  // Most positive two's-complement value of the given width: {0,1...1}.
  function automatic logic [MAX_BITS-1:0] sat_max(input int width);
    logic [MAX_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (i < width - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative two's-complement value of the given width: {1,0...0}.
  function automatic logic [MAX_BITS-1:0] sat_min(input int width);
    logic [MAX_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (i == width - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit adder slice with carry in and carry out.
// Latency: none (purely combinational).
// Backpressure: none; the enclosing pipeline decides when results are kept.
// Ports: a, b (W bits), cin -> sum (W bits), cout.
module adder_chunk
  import adder_pipe_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined NUM_BITS ripple-carry adder, one CHUNK-wide slice per stage.
// Latency: result valid NUM_STAGES-1 edges after the accept edge; 1 item/cycle.
// Backpressure: valid/ready on both sides; a full stalled pipe drops in_ready.
// Ports: clk, n_rst (async active-low), clear (sync flush),
//        a/b/carry_in + in_valid/in_ready (operand side),
//        sum/carry_out/overflow + out_valid/out_ready (result side).
// Build option: define ADDER_PIPE_SAT_EN to saturate sum on signed overflow.
module adder_pipe_nbit
  import adder_pipe_pkg::*;
#(
  parameter int NUM_BITS   = 16,
  parameter int NUM_STAGES = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [NUM_BITS-1:0] sum,
  output logic                carry_out,
  output logic                overflow,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CHUNK = chunk_width(NUM_BITS, NUM_STAGES);
  localparam int LAST  = NUM_STAGES - 1;

  // Stage registers. word_q[k] carries the sum bits of chunks 0..k in its
  // low bits and the still-unadded A bits above them, so A needs no
  // separate storage. brem_q[k] holds the unadded B bits, shifted down so
  // the next chunk to add always sits at bit 0.
  stage_t              st_q   [NUM_STAGES];
  logic [NUM_BITS-1:0] word_q [NUM_STAGES];
  logic [NUM_BITS-1:0] brem_q [NUM_STAGES];

  stage_t              st_d   [NUM_STAGES];
  logic [NUM_BITS-1:0] word_d [NUM_STAGES];
  logic [NUM_BITS-1:0] brem_d [NUM_STAGES];

  logic [CHUNK-1:0]      ca [NUM_STAGES];
  logic [CHUNK-1:0]      cb [NUM_STAGES];
  logic [CHUNK-1:0]      cs [NUM_STAGES];
  logic [NUM_STAGES-1:0] ci;
  logic [NUM_STAGES-1:0] co;

  logic [NUM_STAGES-1:0] adv;
  logic [NUM_STAGES-1:0] load;

  // A stage moves on when the consumer takes the tail, or when any stage
  // downstream of it is empty (that bubble collapses this cycle). This is
  // the unrolled form of adv[k] = vld[k] & (!vld[k+1] | adv[k+1]) and
  // avoids a vector that feeds back into itself.
  always_comb begin
    logic hole;
    hole = 1'b0;
    adv  = '0;
    for (int k = LAST; k >= 0; k--) begin
      adv[k] = st_q[k].vld & (out_ready | hole);
      hole   = hole | ~st_q[k].vld;
    end
  end

  assign in_ready = ~st_q[0].vld | adv[0];

  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int k = 1; k < NUM_STAGES; k++) begin
      load[k] = adv[k-1];
    end
  end

  // Slice operands: stage 0 adds straight from the inputs, later stages
  // from the registers of the stage before.
  always_comb begin
    ca[0] = a[CHUNK-1:0];
    cb[0] = b[CHUNK-1:0];
    ci[0] = carry_in;
    for (int k = 1; k < NUM_STAGES; k++) begin
      ca[k] = word_q[k-1][k*CHUNK +: CHUNK];
      cb[k] = brem_q[k-1][CHUNK-1:0];
      ci[k] = st_q[k-1].carry;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_chunk
    adder_chunk #(.W(CHUNK)) u_chunk (
      .a    (ca[k]),
      .b    (cb[k]),
      .cin  (ci[k]),
      .sum  (cs[k]),
      .cout (co[k])
    );
  end

  // Values each stage captures when it loads.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      st_d[k]   = '0;
      word_d[k] = '0;
      brem_d[k] = '0;
    end
    st_d[0].vld          = 1'b1;
    st_d[0].carry        = co[0];
    st_d[0].a_msb        = a[NUM_BITS-1];
    st_d[0].b_msb        = b[NUM_BITS-1];
    word_d[0]            = a;
    word_d[0][CHUNK-1:0] = cs[0];
    brem_d[0]            = b >> CHUNK;
    for (int k = 1; k < NUM_STAGES; k++) begin
      st_d[k]                     = st_q[k-1];
      st_d[k].vld                 = 1'b1;
      st_d[k].carry               = co[k];
      word_d[k]                   = word_q[k-1];
      word_d[k][k*CHUNK +: CHUNK] = cs[k];
      brem_d[k]                   = brem_q[k-1] >> CHUNK;
    end
  end

  // Data only changes on load, so a stalled tail holds its result steady.
  // clear is applied last so it wins over a same-cycle load.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        st_q[k]   <= '0;
        word_q[k] <= '0;
        brem_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (load[k]) begin
          st_q[k]   <= st_d[k];
          word_q[k] <= word_d[k];
          brem_q[k] <= brem_d[k];
        end else if (adv[k]) begin
          st_q[k].vld <= 1'b0;
        end
        if (clear) begin
          st_q[k].vld <= 1'b0;
        end
      end
    end
  end

  assign out_valid = st_q[LAST].vld;
  assign carry_out = st_q[LAST].carry;
  assign overflow  = (st_q[LAST].a_msb == st_q[LAST].b_msb) &
                     (word_q[LAST][NUM_BITS-1] != st_q[LAST].a_msb);

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [NUM_BITS-1:0] SAT_MAX = NUM_BITS'(sat_max(NUM_BITS));
  localparam logic [NUM_BITS-1:0] SAT_MIN = NUM_BITS'(sat_min(NUM_BITS));

  // Overflow implies both operands share a sign; clamp toward that sign.
  assign sum = overflow ? (st_q[LAST].a_msb ? SAT_MIN : SAT_MAX) : word_q[LAST];
`else
  assign sum = word_q[LAST];
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
module tb_adder_pipe_nbit;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [15:0] OVF_POS_SUM = 16'h7FFF;
  localparam logic [15:0] OVF_NEG_SUM = 16'h8000;
`else
  localparam logic [15:0] OVF_POS_SUM = 16'h8000;
  localparam logic [15:0] OVF_NEG_SUM = 16'h7FFF;
`endif

  logic        clk;
  logic        n_rst;
  logic        clear;
  logic [15:0] a, b;
  logic        carry_in, in_valid, in_ready;
  logic [15:0] sum;
  logic        carry_out, overflow, out_valid, out_ready;

  logic [3:0]  a2, b2, sum2;
  logic        c2, iv2, ir2, cout2, ovf2, out_valid2, out_ready2;

  int   vectors;
  int   miscompares;
  exp_t sb[$];

  adder_pipe_nbit #(.NUM_BITS(16), .NUM_STAGES(4)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .a(a), .b(b), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .carry_out(carry_out),
    .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready)
  );

  adder_pipe_nbit #(.NUM_BITS(4), .NUM_STAGES(2)) dut_small (
    .clk(clk), .n_rst(n_rst), .clear(clear), .a(a2), .b(b2), .carry_in(c2),
    .in_valid(iv2), .in_ready(ir2), .sum(sum2), .carry_out(cout2),
    .overflow(ovf2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: w-bit a+b+cin, carry, signed overflow, optional clamp.
  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y,
                                 input logic cin);
    logic [16:0] full;
    logic [15:0] mask;
    exp_t        e;
    mask   = 16'hFFFF >> (16 - w);
    full   = {1'b0, x & mask} + {1'b0, y & mask} + {16'h0, cin};
    e.cout = full[w];
    e.sum  = full[15:0] & mask;
    e.ovf  = (x[w-1] == y[w-1]) && (e.sum[w-1] != x[w-1]);
`ifdef ADDER_PIPE_SAT_EN
    if (e.ovf) e.sum = x[w-1] ? (16'h1 << (w - 1)) : (mask >> 1);
`endif
    return e;
  endfunction

  task automatic test_reset();
    n_rst = 1'b0;
    #3;
    vectors++;
    if ({out_valid, in_ready, sum, carry_out, overflow} !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got vld=%b rdy=%b sum=%h co=%b ov=%b, expected 0 1 0000 0 0",
               out_valid, in_ready, sum, carry_out, overflow);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 16'h0}) begin
        miscompares++;
        $display("FAIL reset_idle: got vld=%b rdy=%b sum=%h, expected 0 1 0000",
                 out_valid, in_ready, sum);
      end
    end
  endtask

  task automatic test_single(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                             input logic tc, input logic [15:0] es, input logic ec,
                             input logic eo);
    int lat;
    lat = -1;
    @(negedge clk);
    a = ta; b = tb_v; carry_in = tc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_accept: got in_ready=%b expected 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (lat != 3) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles expected 3", name, lat);
    end
    vectors++;
    if ({sum, carry_out, overflow} !== {es, ec, eo}) begin
      miscompares++;
      $display("FAIL %s_result: got sum=%h co=%b ov=%b expected sum=%h co=%b ov=%b",
               name, sum, carry_out, overflow, es, ec, eo);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: got out_valid=%b expected 0", name, out_valid);
    end
  endtask

  task automatic test_stall();
    int   sent, got, stall_left;
    logic seen_first;
    logic [17:0] held;
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    exp_t e;
    sent = 0; got = 0; stall_left = 0; seen_first = 1'b0; held = '0;
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom);
    end
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      @(negedge clk);
      if (!seen_first && out_valid) begin
        seen_first = 1'b1;
        stall_left = 3;
        held = {sum, carry_out, overflow};
      end
      if (sent < 8) begin
        in_valid = 1'b1; a = va[sent]; b = vb[sent]; carry_in = vc[sent];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (stall_left == 0);
      #1;
      if (!out_ready) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_in_ready: got %b expected 0 with 4 items held", in_ready);
        end
        vectors++;
        if ({sum, carry_out, overflow} !== held) begin
          miscompares++;
          $display("FAIL stall_stable: got %h expected %h", {sum, carry_out, overflow}, held);
        end
        stall_left--;
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL stall_extra: got result %h expected none pending", sum);
        end else begin
          e = sb.pop_front();
          if ({sum, carry_out, overflow} !== e) begin
            miscompares++;
            $display("FAIL stall_item%0d: got %h expected %h", got, {sum, carry_out, overflow}, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(16, a, b, carry_in));
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (got != 8 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL stall_count: got %0d results (%0d pending) expected 8 (0)", got, sb.size());
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_dup: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_flush(input logic use_reset);
    logic seen;
    seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h0100 * 16'(i + 1); b = 16'h0003; carry_in = 1'b0;
    end
    @(negedge clk);
    if (use_reset) begin
      in_valid = 1'b0;
      n_rst = 1'b0;
      #1;
      vectors++;
      if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 16'h0}) begin
        miscompares++;
        $display("FAIL rst_flush: got vld=%b rdy=%b sum=%h expected 0 1 0000",
                 out_valid, in_ready, sum);
      end
      @(negedge clk);
      n_rst = 1'b1;
    end else begin
      clear = 1'b1;
      a = 16'hBEEF;
      #1;
      @(negedge clk);
      clear = 1'b0;
      in_valid = 1'b0;
      #1;
      vectors++;
      if ({out_valid, in_ready} !== 2'b01) begin
        miscompares++;
        $display("FAIL clear_flush: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL %s_leak: got a result after flush expected none",
               use_reset ? "rst" : "clear");
    end
  endtask

  task automatic test_small_exhaustive();
    int sent, got;
    logic [8:0] idx;
    exp_t e;
    sent = 0; got = 0;
    sb.delete();
    for (int cyc = 0; cyc < 4000 && got < 512; cyc++) begin
      @(negedge clk);
      if (sent < 512) begin
        idx = 9'(sent);
        a2 = idx[3:0]; b2 = idx[7:4]; c2 = idx[8]; iv2 = 1'b1;
      end else begin
        iv2 = 1'b0;
      end
      out_ready2 = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid2 && out_ready2) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL small_extra: got result %h expected none pending", sum2);
        end else begin
          e = sb.pop_front();
          if ({12'h0, sum2, cout2, ovf2} !== e) begin
            miscompares++;
            $display("FAIL small_item%0d: got %h expected %h", got,
                     {12'h0, sum2, cout2, ovf2}, e);
          end
        end
        got++;
      end
      if (iv2 && ir2) begin
        sb.push_back(model(4, {12'h0, a2}, {12'h0, b2}, c2));
        sent++;
      end
    end
    iv2 = 1'b0;
    out_ready2 = 1'b1;
    vectors++;
    if (got != 512) begin
      miscompares++;
      $display("FAIL small_count: got %0d results expected 512", got);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    n_rst = 1'b0; clear = 1'b0;
    a = '0; b = '0; carry_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a2 = '0; b2 = '0; c2 = 1'b0; iv2 = 1'b0; out_ready2 = 1'b1;

    test_reset();
    test_single("carry8",   16'h00FF, 16'h0001, 1'b0, 16'h0100,    1'b0, 1'b0);
    test_single("ripple",   16'hFFFF, 16'h0000, 1'b1, 16'h0000,    1'b1, 1'b0);
    test_single("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, OVF_POS_SUM, 1'b0, 1'b1);
    test_single("ovf_neg",  16'h8000, 16'hFFFF, 1'b0, OVF_NEG_SUM, 1'b1, 1'b1);
    test_single("plain",    16'h1234, 16'h4321, 1'b1, 16'h5556,    1'b0, 1'b0);
    test_stall();
    test_flush(1'b0);
    test_flush(1'b1);
    test_small_exhaustive();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_pipe_nbit.md
Name: adder_pipe_nbit

Overview:
- Parametrised, pipelined N-bit ripple-carry adder; successor to the combinational single-bit adder.
- Splits the operand into NUM_STAGES equal chunks, one chunk per register stage, with the carry passed forward between stages.
- Uses a valid/ready streaming handshake on both sides, so it sits between an operand producer and a result consumer.
- Reports carry-out and signed overflow for every result.

Parameters:
- NUM_BITS, 16, operand and sum width; must be at least 2.
- NUM_STAGES, 4, pipeline depth; must divide NUM_BITS exactly. CHUNK = NUM_BITS/NUM_STAGES.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of all stages.
- a  in  NUM_BITS  operand A.
- b  in  NUM_BITS  operand B.
- carry_in  in  1  carry into bit 0.
- in_valid  in  1  operand set is valid.
- in_ready  out  1  block accepts operands this cycle.
- sum  out  NUM_BITS  result.
- carry_out  out  1  carry out of the MSB.
- overflow  out  1  two's-complement overflow.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (n_rst=0, asynchronous): all stage valid bits = 0, all data registers = 0, so sum=0, carry_out=0, overflow=0, out_valid=0, in_ready=1.
- Stage k (0..NUM_STAGES-1) holds:
  - valid[k];
  - carry c[k];
  - the sum bits already computed for chunks 0..k;
  - the raw a/b bits of chunks k+1..NUM_STAGES-1 not yet added;
  - the MSBs of a and b, kept for the overflow check.
- Stage 0 loads on accept. It adds chunk 0 of a+b+carry_in.
- Stage k>0 adds chunk k of the delayed operands plus c[k-1].
- Advance rules:
  - adv[last] = valid[last] & out_ready.
  - adv[k] = valid[k] & (!valid[k+1] | adv[k+1]).
  - The ready chain is combinational, so a full pipeline moves one item per cycle when out_ready=1.
- in_ready = !valid[0] | adv[0]. A transfer occurs on in_valid & in_ready.
- Latency: an operand set accepted at edge T gives out_valid=1 after edge T+NUM_STAGES-1, when there is no stall. Throughput is 1 per cycle.
- Output signals:
  - out_valid = valid[last].
  - sum, carry_out and overflow are driven directly from the last-stage registers.
  - They stay stable while out_valid & !out_ready.
- overflow = (a_msb==b_msb) & (sum_msb!=a_msb). carry_in is included in the sum.
- Arithmetic is modulo 2^NUM_BITS. carry_out is bit NUM_BITS of a+b+carry_in.
- Boundaries:
  - Full pipeline with out_ready=0: in_ready=0, no stage moves, no data is lost or duplicated.
  - Bubbles collapse: an empty stage always accepts from the stage before it.
  - clear=1: all valid bits go to 0 at the next edge. Any accept in that cycle is discarded; clear has priority.
  - n_rst asserted mid-stream: all in-flight items are dropped immediately.
  - Results leave in strict FIFO order.

Optional Feature:
- Macro: ADDER_PIPE_SAT_EN.
- Defined: when overflow=1, sum saturates to the most positive value ({0,1...1}) if a_msb=0, otherwise to the most negative value ({1,0...0}). overflow still reports 1. carry_out is unchanged.
- Undefined: sum wraps and overflow is flag-only.

Decomposition:
- Package adder_pipe_pkg holds:
  - the CHUNK computation function;
  - the saturation constants function (max/min for a given width);
  - a stage-register struct typedef.
- Sub-module adder_chunk: a combinational CHUNK-bit adder with carry in/out, instantiated NUM_STAGES times.
- The top level owns the stage registers, handshake and overflow/saturation logic.

Test Plan:
1. Reset with n_rst=0 -> out_valid=0, in_ready=1, sum=16'h0000; all stay at these values until the first accept.
2. a=16'h00FF, b=16'h0001, carry_in=0, single item -> out_valid exactly 3 cycles after the accept edge; sum=16'h0100, carry_out=0, overflow=0.
3. a=16'hFFFF, b=16'h0000, carry_in=1 -> sum=16'h0000, carry_out=1, overflow=0 (carry ripples through all 4 stages).
4. a=16'h7FFF, b=16'h0001 -> overflow=1; sum=16'h8000 without the macro, 16'h7FFF with it. a=16'h8000, b=16'hFFFF gives sum=16'h7FFF or 16'h8000 respectively, carry_out=1.
5. Stream of 8 items with out_ready=0 for 3 cycles after the first result -> in_ready drops once 4 items are held; all 8 results arrive in order, none lost or duplicated; sum stays stable during the stall.
6. clear pulsed and then n_rst pulsed, each with 3 items in flight -> out_valid=0 the next cycle and in_ready=1; then exhaustive/random comparison against a+b+carry_in on a 4-bit, 2-stage build.
